// File: rtl/div_pkg.sv
// Shared encodings and constants for the sequential divider.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Divide-by-zero quotient pattern; sliced down to the operand width at use.
  localparam int DZ_MAX_WIDTH = 64;
  localparam logic [DZ_MAX_WIDTH-1:0] DZ_QUO_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             unusedDiffMsb;

  // rem < divisor on entry, so a kept difference always fits in WIDTH bits
  always_comb begin
    shifted       = {remIn, quoIn[WIDTH-1]};
    trial         = {1'b0, shifted} - {2'b00, divisor};
    borrow        = trial[WIDTH+1];
    unusedDiffMsb = trial[WIDTH];
    quoOut        = {quoIn[WIDTH-2:0], ~borrow};
    remOut        = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX; stalls the
// pipeline while iterating and presents {remainder, quotient} with a ready pulse.
//
//   state  | meaning
//   S_IDLE | waiting for start_i; operands captured on accept
//   S_BUSY | one restoring step per cycle, WIDTH steps
//   S_DONE | sign fix-up, register result_o and ready_o, back to idle
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit ZERO_EARLY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic             quoNeg;
  logic             remNeg;

  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] remFix;
  logic [WIDTH-1:0] quoFix;

  always_comb begin
    aNeg   = signed_i & a_i[WIDTH-1];
    bNeg   = signed_i & b_i[WIDTH-1];
    absA   = aNeg ? -a_i : a_i;
    absB   = bNeg ? -b_i : b_i;
    remFix = remNeg ? -remReg : remReg;
    quoFix = quoNeg ? -quoReg : quoReg;
  end

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divReg),
    .remOut (remNext),
    .quoOut (quoNext)
  );

  // Combinational so the accepting cycle already holds the pipeline.
  assign stall_o = ~annul_i & (((state == S_IDLE) & start_i) | (state == S_BUSY));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      remReg   <= '0;
      quoReg   <= '0;
      divReg   <= '0;
      quoNeg   <= 1'b0;
      remNeg   <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            count  <= '0;
            divReg <= absB;
            if (ZERO_EARLY && (b_i == '0)) begin
              // Early zero-divisor result is the raw dividend, no sign fix.
              state  <= S_DONE;
              remReg <= a_i;
              quoReg <= DZ_QUO_ONES[WIDTH-1:0];
              quoNeg <= 1'b0;
              remNeg <= 1'b0;
            end else begin
              state  <= S_BUSY;
              remReg <= '0;
              quoReg <= absA;
              quoNeg <= aNeg ^ bNeg;
              remNeg <= aNeg;
            end
          end
        end
        S_BUSY: begin
          if (annul_i) begin
            state <= S_IDLE;
            count <= '0;
          end else begin
            remReg <= remNext;
            quoReg <= quoNext;
            count  <= count + CW'(1);
            if (count == LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!annul_i) begin
            ready_o  <= 1'b1;
            result_o <= {remFix, quoFix};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: one instance with the zero-divisor shortcut,
// one without; expected {rem, quo} queued at start and popped on ready_o.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startE = 1'b0;
  logic        startZ = 1'b0;
  logic        signedIn = 1'b0;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;
  logic        annulIn = 1'b0;
  logic        stallE, readyE, stallZ, readyZ;
  logic [63:0] resultE, resultZ;

  int checks = 0;
  int errors = 0;
  logic [63:0] qE[$];
  logic [63:0] qZ[$];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32), .ZERO_EARLY(1'b1)) dutE (
    .clk(clk), .rst(rst), .start_i(startE), .signed_i(signedIn), .a_i(aIn), .b_i(bIn),
    .annul_i(annulIn), .stall_o(stallE), .ready_o(readyE), .result_o(resultE)
  );

  div_seq #(.WIDTH(32), .ZERO_EARLY(1'b0)) dutZ (
    .clk(clk), .rst(rst), .start_i(startZ), .signed_i(signedIn), .a_i(aIn), .b_i(bIn),
    .annul_i(annulIn), .stall_o(stallZ), .ready_o(readyZ), .result_o(resultZ)
  );

  always @(negedge clk) begin
    if (readyE) begin
      checks++;
      if (qE.size() == 0) begin
        errors++;
        $display("FAIL scoreboardE: unexpected ready_o, result %h", resultE);
      end else begin
        logic [63:0] exp;
        exp = qE.pop_front();
        if (resultE !== exp) begin
          errors++;
          $display("FAIL scoreboardE: result %h expected %h", resultE, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (readyZ) begin
      checks++;
      if (qZ.size() == 0) begin
        errors++;
        $display("FAIL scoreboardZ: unexpected ready_o, result %h", resultZ);
      end else begin
        logic [63:0] exp;
        exp = qZ.pop_front();
        if (resultZ !== exp) begin
          errors++;
          $display("FAIL scoreboardZ: result %h expected %h", resultZ, exp);
        end
      end
    end
  end

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Pipeline-style op: start held while stall_o is high, dropped after DONE.
  task automatic runOp(input bit useZ, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expRes, input int expLat, input int expStall, input string name);
    int cyc, stallCnt, readyAt;
    bit s, r;
    signedIn = sgn; aIn = a; bIn = b;
    if (useZ) begin startZ = 1'b1; qZ.push_back(expRes); end
    else      begin startE = 1'b1; qE.push_back(expRes); end
    cyc = 0; stallCnt = 0; readyAt = -1;
    while (readyAt < 0 && cyc < 100) begin
      @(negedge clk);
      s = useZ ? stallZ : stallE;
      r = useZ ? readyZ : readyE;
      if (s) stallCnt++;
      if (r) readyAt = cyc;
      cyc++;
      @(posedge clk); #1;
      if (!s) begin startE = 1'b0; startZ = 1'b0; end
    end
    startE = 1'b0; startZ = 1'b0;
    checks++;
    if (readyAt != expLat) begin
      errors++;
      $display("FAIL %s latency: ready at cycle %0d expected %0d", name, readyAt, expLat);
    end
    checks++;
    if (stallCnt != expStall) begin
      errors++;
      $display("FAIL %s stall: %0d cycles expected %0d", name, stallCnt, expStall);
    end
    @(negedge clk);
    checks++;
    if ((useZ ? readyZ : readyE) !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: ready_o still %b expected 0", name, useZ ? readyZ : readyE);
    end
    checks++;
    if ((useZ ? resultZ : resultE) !== expRes) begin
      errors++;
      $display("FAIL %s hold: result %h expected %h", name, useZ ? resultZ : resultE, expRes);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({readyE, stallE, resultE} !== 66'h0) begin
      errors++;
      $display("FAIL reset_E: ready %b stall %b result %h expected all 0", readyE, stallE, resultE);
    end
    checks++;
    if ({readyZ, stallZ, resultZ} !== 66'h0) begin
      errors++;
      $display("FAIL reset_Z: ready %b stall %b result %h expected all 0", readyZ, stallZ, resultZ);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    runOp(0, 0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 33, "divu_100_7");
    runOp(0, 1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 33, "div_m7_2");
    runOp(0, 1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34, 33, "div_7_m2");
    runOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 33, "div_overflow");
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      bit sgn;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'h0) b = 32'h3;
      sgn = i[0];
      runOp(0, sgn, a, b, model(sgn, a, b), 34, 33, "random");
    end
  endtask

  task automatic test_div_zero;
    runOp(0, 0, 32'd5, 32'd0, model(0, 32'd5, 32'd0), 2, 1, "divu_5_0_early");
    runOp(1, 0, 32'd5, 32'd0, model(0, 32'd5, 32'd0), 34, 33, "divu_5_0_full");
  endtask

  task automatic test_annul;
    bit sawReady, sawStall;
    signedIn = 1'b0; aIn = 32'd100; bIn = 32'd7;
    startE = 1'b1; annulIn = 1'b1;
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0) begin
      errors++;
      $display("FAIL annul_idle: stall %b expected 0", stallE);
    end
    @(posedge clk); #1;
    annulIn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    annulIn = 1'b1;
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0) begin
      errors++;
      $display("FAIL annul_busy: stall %b expected 0", stallE);
    end
    @(posedge clk); #1;
    annulIn = 1'b0; startE = 1'b0;
    sawReady = 1'b0; sawStall = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (readyE) sawReady = 1'b1;
      if (stallE) sawStall = 1'b1;
    end
    checks++;
    if (sawReady || sawStall) begin
      errors++;
      $display("FAIL annul_quiet: ready seen %b stall seen %b expected 0 0", sawReady, sawStall);
    end
    @(posedge clk); #1;
    runOp(0, 0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 33, "divu_9_3_after_annul");
  endtask

  task automatic test_reset_mid;
    signedIn = 1'b0; aIn = 32'd100; bIn = 32'd7; startE = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b0; startE = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({readyE, stallE, resultE} !== 66'h0) begin
      errors++;
      $display("FAIL reset_mid: ready %b stall %b result %h expected all 0", readyE, stallE, resultE);
    end
    startE = 1'b1;
    #1;
    checks++;
    if (stallE !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_start: stall %b expected 1", stallE);
    end
    @(posedge clk); #1;
    startE = 1'b0; rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (readyE) begin
        errors++;
        $display("FAIL reset_mid_pulse: ready_o %b after abandoned op expected 0", readyE);
      end
    end
    checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] opA[3] = '{32'd1000, 32'd77, 32'hFFFF_FFFF};
    logic [31:0] opB[3] = '{32'd10, 32'd5, 32'd16};
    int idx, pulses, cyc, lastReady;
    bit s;
    signedIn = 1'b0;
    idx = 0; pulses = 0; cyc = 0; lastReady = -1;
    aIn = opA[0]; bIn = opB[0]; startE = 1'b1;
    qE.push_back(model(0, opA[0], opB[0]));
    while (pulses < 3 && cyc < 200) begin
      @(negedge clk);
      s = stallE;
      if (readyE) begin pulses++; lastReady = cyc; end
      cyc++;
      @(posedge clk); #1;
      if (!s) begin
        idx++;
        if (idx < 3) begin
          aIn = opA[idx]; bIn = opB[idx];
          qE.push_back(model(0, opA[idx], opB[idx]));
        end else startE = 1'b0;
      end
    end
    startE = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (readyE) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL b2b_pulses: %0d ready pulses expected 3", pulses);
    end
    checks++;
    if (lastReady != 102) begin
      errors++;
      $display("FAIL b2b_timing: last ready at cycle %0d expected 102", lastReady);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_random();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (qE.size() != 0 || qZ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d results never produced expected 0/0", qE.size(), qZ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider sequencer for the MIPS 5-stage pipeline.
- Executes DIV/DIVU from the execute stage and holds the pipeline via a stall request while iterating.
- Presents {HI=remainder, LO=quotient} for the HI/LO write in the memory stage.
- Replaces the single-cycle divide path; its stall output feeds the hazard unit, which drives the execute-stage stall.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- ZERO_EARLY, 1, if 1 a zero divisor skips the BUSY iterations and goes straight to DONE.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low; also the reset for all state.
- start_i  input  1  a divide instruction is present in EX; held high by the pipeline while stalled.
- signed_i  input  1  1=DIV (signed), 0=DIVU; sampled with start_i.
- a_i  input  WIDTH  dividend; sampled with start_i.
- b_i  input  WIDTH  divisor; sampled with start_i.
- annul_i  input  1  flush/exception cancels the operation in progress.
- stall_o  output  1  pipeline stall request to the hazard unit.
- ready_o  output  1  one-cycle pulse: result_o valid, HI/LO may be written.
- result_o  output  2*WIDTH  {remainder, quotient}.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, counter=0, ready_o=0, result_o=0. Reset mid-operation abandons it with no ready_o pulse.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - start_i=1 and annul_i=0 at an edge: capture |a|, |b| (absolute values only if signed_i=1), quotient sign = a[msb]^b[msb] (signed only), remainder sign = a[msb] (signed only), counter=0.
  - Next state is BUSY; if ZERO_EARLY=1 and b_i=0, next state is DONE.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left by 1, trial-subtract the divisor, keep the result if non-negative, set quo[0].
  - Counter increments; after the step with counter=WIDTH-1, go to DONE. This is exactly WIDTH iterations.
- DONE:
  - Apply signs: negate quotient if its sign is set; negate remainder if its sign is set.
  - Register result_o, ready_o=1 for this one cycle, then return to IDLE.
  - start_i still high during DONE is the same instruction and is ignored; a new operation needs start_i sampled in IDLE.
- Latency: start sampled at edge k gives ready_o high in the cycle after edge k+WIDTH+1, i.e. 33 cycles for WIDTH=32. With the ZERO_EARLY zero-divisor path, ready_o is high in the cycle after edge k+1.
- stall_o = ~annul_i & ((state==IDLE & start_i) | state==BUSY). This is combinational so the start cycle stalls. It is low in DONE so the instruction advances carrying the result.
- ready_o stays registered, high only in DONE; result_o holds its last value until the next DONE.
- annul_i=1 in BUSY or DONE: next state is IDLE and ready_o is forced 0 in that cycle. annul_i in IDLE blocks start.
- Divide by zero (either path): quotient = all ones, remainder = dividend. Signed case uses the sign-adjusted values from the normal algorithm; with ZERO_EARLY, remainder = a_i and quotient = all ones, with no sign fix.
- Overflow case 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0, no trap.
- Widths: the remainder datapath is WIDTH+1 bits internally for the trial subtract; the counter is clog2(WIDTH) bits and wraps to 0 on entering DONE.

Decomposition:
- Shared package div_pkg: state encodings (S_IDLE, S_BUSY, S_DONE) and the divide-by-zero result constants.
- One sub-module, div_step: a combinational single restoring iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo. It is instantiated once in BUSY.
- Sign handling and control stay in div_seq.

Test Plan:
- DIVU 100/7: start 1 cycle then held -> stall_o high 33 cycles, ready_o on cycle 34, result_o = {0x00000002, 0x0000000E}.
- DIV -7/2 (0xFFFFFFF9/0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}, normal 33-cycle latency.
- DIVU 5/0 with ZERO_EARLY=1 -> ready_o on cycle 2, result_o = {0x00000005, 0xFFFFFFFF}; with ZERO_EARLY=0 -> same value at cycle 34.
- annul_i pulsed at BUSY iteration 10 -> stall_o drops the same cycle, no ready_o, state returns to IDLE; a following DIVU 9/3 completes normally with {0, 3}.
- rst=0 mid-BUSY -> the next cycle shows ready_o=0, result_o=0, stall_o=0 unless start_i is present. Back-to-back DIVUs (start re-asserted the cycle after DONE) each yield exactly one ready_o pulse.
